// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM states, default widths and the captured run configuration.
package counter_seq_pkg;

  localparam int CSQ_WIDTH   = 4;
  localparam int CSQ_PRESC_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The shadow configuration is sized by the package widths; keep them in step with any top-level override.
  typedef struct packed {
    logic [CSQ_WIDTH-1:0]   load;
    logic [CSQ_WIDTH-1:0]   term;
    logic [CSQ_PRESC_W-1:0] presc;
    logic                   reload;
  } cfg_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between the timer's controlling logic (master) and the counter sequencer (slave).
interface counter_sequencer_if #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
);

  logic               start;
  logic               stop;
  logic [WIDTH-1:0]   cfg_load;
  logic [WIDTH-1:0]   cfg_term;
  logic [PRESC_W-1:0] cfg_presc;
  logic               cfg_reload;
  logic               ready;
  logic               busy;
  logic [WIDTH-1:0]   count;
  logic               tick;
  logic               done;

  modport master (
    output start, stop, cfg_load, cfg_term, cfg_presc, cfg_reload,
    input  ready, busy, count, tick, done
  );

  modport slave (
    input  start, stop, cfg_load, cfg_term, cfg_presc, cfg_reload,
    output ready, busy, count, tick, done
  );

endinterface

// File: rtl/counter_core.sv
// Loadable WIDTH-bit synchronous up-counter; wraps naturally from all-ones to zero.
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Programmable timer controller: captures a configuration on start and steps counter_core once per prescaled tick.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH   = CSQ_WIDTH,
  parameter int PRESC_W = CSQ_PRESC_W
) (
  input  logic              clk,
  input  logic              rst,
  counter_sequencer_if.slave bus
);

  state_t             state;
  state_t             next_state;
  cfg_t               shadow;
  logic [PRESC_W-1:0] presc_cnt;
  logic [WIDTH-1:0]   count;
  logic               tick_q;
  logic               raw_step;
  logic               step;
  logic               at_term;
  logic               core_load;
  logic               core_en;
  logic [WIDTH-1:0]   core_load_val;

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (core_load_val),
    .en       (core_en),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = ARM;
      ARM:  next_state = bus.stop ? IDLE : RUN;
      RUN: begin
        if (bus.stop) begin
          next_state = IDLE;
        end else if (step && at_term && !shadow.reload) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A stop in the same cycle suppresses the step entirely, so the count freezes and no tick follows.
  always_comb begin
    raw_step      = (state == RUN) && (presc_cnt == PRESC_W'(shadow.presc));
    step          = raw_step && !bus.stop;
    at_term       = (count == WIDTH'(shadow.term));
    core_load     = ((state == IDLE) && bus.start) || (step && at_term && shadow.reload);
    core_load_val = (state == IDLE) ? bus.cfg_load : WIDTH'(shadow.load);
    core_en       = step && !at_term;
    bus.ready     = (state == IDLE);
    bus.busy      = (state == ARM) || (state == RUN);
    bus.done      = (state == DONE);
    bus.tick      = tick_q;
    bus.count     = count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      shadow    <= '0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= step && at_term;
      if ((state == IDLE) && bus.start) begin
        shadow <= '{load:   CSQ_WIDTH'(bus.cfg_load),
                    term:   CSQ_WIDTH'(bus.cfg_term),
                    presc:  CSQ_PRESC_W'(bus.cfg_presc),
                    reload: bus.cfg_reload};
      end
      if ((state == RUN) && !bus.stop && !raw_step) begin
        presc_cnt <= presc_cnt + PRESC_W'(1);
      end else begin
        presc_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: per-cycle expected outputs go through a scoreboard queue.
module tb_counter_sequencer;

  localparam int WIDTH   = 4;
  localparam int PRESC_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             ready;
    logic             busy;
    logic             tick;
    logic             done;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  obs_t expq[$];
  int   errors = 0;
  int   checks = 0;

  counter_sequencer_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  counter_sequencer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic s, input logic p, input logic [WIDTH-1:0] ld,
                               input logic [WIDTH-1:0] tm, input logic [PRESC_W-1:0] pr,
                               input logic rl);
    bus.start      = s;
    bus.stop       = p;
    bus.cfg_load   = ld;
    bus.cfg_term   = tm;
    bus.cfg_presc  = pr;
    bus.cfg_reload = rl;
  endtask

  task automatic checkOutput(input string tag);
    obs_t obs;
    obs_t exp;
    obs = {bus.count, bus.ready, bus.busy, bus.tick, bus.done};
    checks++;
    assert (expq.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s: scoreboard empty, observed %h, expected an entry", tag, obs);
    end
    if (expq.size() != 0) begin
      exp = expq.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("[TB] FAIL %s: observed count=%0d ready=%b busy=%b tick=%b done=%b, expected count=%0d ready=%b busy=%b tick=%b done=%b",
               tag, obs.count, obs.ready, obs.busy, obs.tick, obs.done,
               exp.count, exp.ready, exp.busy, exp.tick, exp.done);
      end
    end
  endtask

  // Queue the expectation for the coming edge, then sample one time unit after it.
  task automatic stepCycle(input string tag, input logic [WIDTH-1:0] c,
                           input logic r, input logic b, input logic t, input logic d);
    expq.push_back({c, r, b, t, d});
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input string tag, input logic [WIDTH-1:0] c);
    stepCycle(tag, c, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runCycle(input string tag, input logic [WIDTH-1:0] c);
    stepCycle(tag, c, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] wrap_vals [3];
    wrap_vals = '{4'd15, 4'd0, 4'd1};

    applyStimulus(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    idleCycle("reset_0", 0);
    idleCycle("reset_1", 0);
    rst = 1'b0;
    idleCycle("idle_after_reset", 0);

    // One-shot, one step per cycle
    applyStimulus(1, 0, 3, 7, 0, 0);
    runCycle("os_arm", 3);
    applyStimulus(0, 0, 3, 7, 0, 0);
    runCycle("os_run_first", 3);
    for (int v = 4; v <= 7; v++) runCycle("os_count", WIDTH'(v));
    stepCycle("os_tick_done", 7, 0, 0, 1, 1);
    idleCycle("os_ready", 7);

    // Auto-reload with wrap through zero, prescale 3
    applyStimulus(1, 0, 14, 1, 2, 1);
    runCycle("ar_arm", 14);
    applyStimulus(0, 0, 14, 1, 2, 1);
    for (int k = 0; k < 3; k++) runCycle("ar_load_hold", 14);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) runCycle("ar_wrap", wrap_vals[i]);
      end
      stepCycle("ar_tick", 14, 0, 1, 1, 0);
      if (rep == 0) begin
        runCycle("ar_reload_hold", 14);
        runCycle("ar_reload_hold", 14);
      end
    end
    applyStimulus(0, 1, 14, 1, 2, 1);
    idleCycle("ar_stop", 14);
    applyStimulus(0, 0, 14, 1, 2, 1);
    idleCycle("ar_frozen", 14);

    // Stop lands on the terminal step
    applyStimulus(1, 0, 0, 1, 0, 0);
    runCycle("sp_arm", 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    runCycle("sp_run_first", 0);
    runCycle("sp_at_term", 1);
    applyStimulus(0, 1, 0, 1, 0, 0);
    idleCycle("sp_stop_wins", 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    idleCycle("sp_no_tick", 1);
    applyStimulus(1, 0, 0, 2, 0, 0);
    runCycle("sp2_arm", 0);
    applyStimulus(0, 0, 0, 2, 0, 0);
    runCycle("sp2_run_first", 0);
    runCycle("sp2_count", 1);
    runCycle("sp2_count", 2);
    stepCycle("sp2_tick_done", 2, 0, 0, 1, 1);
    idleCycle("sp2_ready", 2);

    // Start and config changes while busy or in DONE are ignored; stop in IDLE is ignored
    applyStimulus(1, 0, 2, 4, 1, 0);
    runCycle("ig_arm", 2);
    applyStimulus(0, 0, 2, 4, 1, 0);
    runCycle("ig_presc0", 2);
    runCycle("ig_presc1", 2);
    runCycle("ig_step", 3);
    applyStimulus(1, 0, 9, 0, 0, 1);
    runCycle("ig_start_busy", 3);
    applyStimulus(0, 0, 9, 0, 0, 1);
    runCycle("ig_step", 4);
    runCycle("ig_hold", 4);
    stepCycle("ig_tick_done", 4, 0, 0, 1, 1);
    applyStimulus(1, 0, 9, 0, 0, 1);
    idleCycle("ig_start_in_done", 4);
    applyStimulus(0, 1, 9, 0, 0, 1);
    idleCycle("ig_stop_idle", 4);
    idleCycle("ig_stop_idle", 4);

    // Start and stop together in IDLE takes the start; reset mid-run at count 9
    applyStimulus(1, 1, 7, 12, 0, 1);
    runCycle("rs_arm", 7);
    applyStimulus(0, 0, 7, 12, 0, 1);
    runCycle("rs_run_first", 7);
    runCycle("rs_count", 8);
    runCycle("rs_count", 9);
    rst = 1'b1;
    idleCycle("rs_reset", 0);
    rst = 1'b0;
    idleCycle("rs_idle", 0);

    checks++;
    assert (expq.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_drain: observed %0d leftover entries, expected 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that sequences a loadable synchronous up-counter as a programmable timer.
- Accepts a start request with a configuration: start value, terminal value, prescale and mode.
- Steps the counter once per prescaled tick and flags each terminal count. One-shot mode finishes with a done pulse; auto-reload mode runs until stopped.
- Sits between control logic and the counter datapath; it is the only block that drives the counter's load and enable.

Parameters:
- WIDTH, 4, counter width in bits.
- PRESC_W, 4, prescaler width; the counter steps every cfg_presc+1 clocks.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  start request; accepted only while ready=1.
- stop  input  1  abort request; effective in ARM and RUN only.
- cfg_load  input  WIDTH  start/reload value.
- cfg_term  input  WIDTH  terminal value.
- cfg_presc  input  PRESC_W  prescale divisor minus one.
- cfg_reload  input  1  1 = auto-reload, 0 = one-shot.
- ready  output  1  high in IDLE.
- busy  output  1  high in ARM and RUN.
- count  output  WIDTH  current counter value.
- tick  output  1  one-cycle pulse after each terminal step.
- done  output  1  one-cycle pulse on one-shot completion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - count = 0, prescaler count = 0, shadow registers = 0.
  - ready = 1, busy = 0, tick = 0, done = 0.
- Reset mid-operation: any state returns to these values on the next edge.
- All outputs are registered or decoded directly from registered state.
- States: IDLE, ARM, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture cfg_* into shadow registers, set count <= cfg_load, go to ARM.
  - cfg_* is ignored at all other times; configuration changes during a run have no effect.
- ARM: lasts one cycle. Clears the prescaler, then goes to RUN.
- RUN, prescaler:
  - The prescaler increments each cycle.
  - When prescaler == shadow_presc, a step occurs and the prescaler clears.
  - presc = 0 gives one step per cycle.
- RUN, on a step:
  - If count != shadow_term: count <= count+1, modulo 2^WIDTH. If load > term, the count wraps through all-ones to 0 and continues up to term.
  - If count == shadow_term and reload = 1: count <= shadow_load, tick = 1 next cycle, stay in RUN.
  - If count == shadow_term and reload = 0: count holds, tick = 1 next cycle, go to DONE.
- load == term: the first step is a terminal step.
- DONE: done = 1 for exactly this cycle, then go to IDLE. count holds the terminal value.
- stop:
  - In ARM or RUN, stop has priority over a same-cycle step.
  - Go to IDLE next edge; count freezes; no tick, no done.
  - Ignored in IDLE and DONE.
- start while busy or in DONE: ignored, no queuing.
- start and stop together in IDLE: start is taken.
- Latency:
  - start at edge N: busy = 1 and count = load from N+1; RUN from N+2.
  - First step at the end of the (presc+1)th RUN cycle.
- Precedence: rst > stop > step.

Decomposition:
- Package counter_seq_pkg holds:
  - the state enum typedef (IDLE, ARM, RUN, DONE);
  - default WIDTH and PRESC_W constants;
  - a config struct typedef (load, term, presc, reload).
- Sub-module counter_core: WIDTH-bit synchronous counter with load, load value, enable and wrap.
  - The sequencer drives load in IDLE on an accepted start, and on a reload step.
  - It drives enable on non-terminal steps.
  - The terminal compare stays in the sequencer.

Test Plan:
- Reset: hold rst 2 cycles mid-idle → count 0, ready 1, busy 0, tick 0, done 0.
- One-shot, presc=0: load=3, term=7, reload=0, start pulse.
  - count 3 held through ARM and the first RUN cycle, then 4,5,6,7 one per cycle.
  - Next cycle: tick=1 and done=1 together, for one cycle.
  - Then ready=1 with count=7.
- Auto-reload wrap, presc=2: load=14, term=1, reload=1.
  - count 14,15,0,1,14,… each held 3 cycles.
  - tick every 12 cycles; done never asserts.
  - stop after the second tick → IDLE next cycle, count frozen.
- Stop priority: stop asserted in the same cycle as the terminal step → IDLE, no tick, no done. A new start (load=0, term=2) then runs normally.
- Ignored inputs during a run:
  - start pulse and cfg_term=0 change while busy → run unaffected, terminates at the original term.
  - stop in IDLE → no state change.
- Reset mid-run at count=9, WIDTH=4 → next cycle count 0, state IDLE, ready 1, tick and done stay 0.
